// File: rtl/fpga_pkg.sv
// Shared definitions for the program-execution core's I/O channels.
package fpga_pkg;

  localparam int MemoryElementWidthDefault = 12;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } in_channel_state_t;

endpackage

// File: rtl/in_channel_ram.sv
// Channel storage: synchronous write port and a registered read port whose
// output holds its value when no read is requested.
module in_channel_ram #(
  parameter int Width     = 12,
  parameter int Depth     = 2,
  parameter int AddrWidth = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 write_en,
  input  logic [AddrWidth-1:0] write_addr,
  input  logic [Width-1:0]     write_data,
  input  logic                 read_en,
  input  logic [AddrWidth-1:0] read_addr,
  output logic [Width-1:0]     read_data
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clock) begin
    if (write_en) mem[write_addr] <= write_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) read_data <= '0;
    else if (read_en) read_data <= mem[read_addr];
  end

endmodule

// File: rtl/in_channel.sv
// Reloadable input channel: loaded over valid/ready, sealed, then drained by
// the core's in/inSize instructions with a "no data" miss when exhausted.
module in_channel
  import fpga_pkg::*;
#(
  parameter int MemoryElementWidth = MemoryElementWidthDefault,
  parameter int NIn                = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          loadValid,
  input  logic [MemoryElementWidth-1:0] loadData,
  output logic                          loadReady,
  input  logic                          seal,
  input  logic                          inReq,
  output logic [MemoryElementWidth-1:0] inData,
  output logic                          inHit,
  output logic [$clog2(NIn+1)-1:0]      inSize,
  output logic                          sealed,
  output logic                          overflow
);

  localparam int PtrW = (NIn > 1) ? $clog2(NIn) : 1;
  localparam int CntW = $clog2(NIn + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(NIn - 1);
  localparam logic [CntW-1:0] Depth   = CntW'(NIn);

  in_channel_state_t state, state_next;
  logic [PtrW-1:0] wp, rp;
  logic [CntW-1:0] count;
  logic            hit_q, sealed_q, overflow_q;
  logic            load_fire, pop_fire, overflow_set;

  // Explicit wrap so depths that are not a power of two work.
  function automatic logic [PtrW-1:0] bump(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign loadReady = (state == LOAD) && (count < Depth);
  assign inSize    = count;
  assign inHit     = hit_q;
  assign sealed    = sealed_q;
  assign overflow  = overflow_q;

  always_comb begin
    state_next   = state;
    load_fire    = 1'b0;
    pop_fire     = 1'b0;
    overflow_set = 1'b0;
    if (clear) begin
      state_next = LOAD;
    end else begin
      case (state)
        LOAD: begin
          load_fire    = loadValid && loadReady;
          overflow_set = loadValid && !loadReady;
          if (seal) state_next = RUN;
        end
        RUN: pop_fire = inReq && (count != '0);
        default: state_next = LOAD;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= LOAD;
      sealed_q   <= 1'b0;
      hit_q      <= 1'b0;
      overflow_q <= 1'b0;
      wp         <= '0;
      rp         <= '0;
      count      <= '0;
    end else begin
      state    <= state_next;
      sealed_q <= (state_next == RUN);
      hit_q    <= pop_fire;
      if (clear) begin
        wp         <= '0;
        rp         <= '0;
        count      <= '0;
        overflow_q <= 1'b0;
      end else begin
        if (load_fire) begin
          wp    <= bump(wp);
          count <= count + CntW'(1);
        end
        if (pop_fire) begin
          rp    <= bump(rp);
          count <= count - CntW'(1);
        end
        if (overflow_set) overflow_q <= 1'b1;
      end
    end
  end

  in_channel_ram #(
    .Width    (MemoryElementWidth),
    .Depth    (NIn),
    .AddrWidth(PtrW)
  ) u_ram (
    .clock     (clock),
    .reset     (reset),
    .write_en  (load_fire),
    .write_addr(wp),
    .write_data(loadData),
    .read_en   (pop_fire),
    .read_addr (rp),
    .read_data (inData)
  );

endmodule

// File: tb/tb_in_channel.sv
// Self-checking bench: a depth-2 and a depth-3 channel share one stimulus
// stream; directed scenarios plus a random run against a queue model.
module tb_in_channel;

  localparam int W = 12;

  logic         clock = 1'b0;
  logic         rst_n, clear, load_valid, seal, in_req;
  logic [W-1:0] load_data;

  logic         ready_a, hit_a, sealed_a, ovf_a;
  logic [W-1:0] data_a;
  logic [1:0]   size_a;
  logic         ready_b, hit_b, sealed_b, ovf_b;
  logic [W-1:0] data_b;
  logic [1:0]   size_b;

  int tests_run = 0;
  int failures  = 0;

  logic [W-1:0] mq0[$];
  logic [W-1:0] mq1[$];
  bit           m_sealed[2], m_ovf[2], m_hit[2];
  logic [W-1:0] m_data[2];

  always #5 clock = ~clock;

  in_channel #(.MemoryElementWidth(W), .NIn(2)) dut_a (
    .clock(clock), .reset(rst_n), .clear(clear), .loadValid(load_valid),
    .loadData(load_data), .loadReady(ready_a), .seal(seal), .inReq(in_req),
    .inData(data_a), .inHit(hit_a), .inSize(size_a), .sealed(sealed_a),
    .overflow(ovf_a)
  );

  in_channel #(.MemoryElementWidth(W), .NIn(3)) dut_b (
    .clock(clock), .reset(rst_n), .clear(clear), .loadValid(load_valid),
    .loadData(load_data), .loadReady(ready_b), .seal(seal), .inReq(in_req),
    .inData(data_b), .inHit(hit_b), .inSize(size_b), .sealed(sealed_b),
    .overflow(ovf_b)
  );

  // Inputs change 1 time unit after the edge; outputs are read at the same offset.
  task automatic drive(input bit c, input bit lv, input logic [W-1:0] d,
                       input bit s, input bit r);
    clear = c; load_valid = lv; load_data = d; seal = s; in_req = r;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, '0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clear = 0; load_valid = 0; load_data = '0; seal = 0; in_req = 0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    rst_n = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    for (int k = 0; k < 2; k++) begin
      m_sealed[k] = 0; m_ovf[k] = 0; m_hit[k] = 0; m_data[k] = '0;
    end
  endtask

  // Behavioural channel: a bounded queue that is loaded, then sealed, then popped.
  task automatic model_step(input int k, input int depth, input bit c, input bit lv,
                            input logic [W-1:0] d, input bit s, input bit r);
    int sz;
    sz = (k == 0) ? mq0.size() : mq1.size();
    m_hit[k] = 0;
    if (c) begin
      if (k == 0) mq0.delete(); else mq1.delete();
      m_sealed[k] = 0;
      m_ovf[k] = 0;
    end else if (!m_sealed[k]) begin
      if (lv) begin
        if (sz < depth) begin
          if (k == 0) mq0.push_back(d); else mq1.push_back(d);
        end else m_ovf[k] = 1;
      end
      if (s) m_sealed[k] = 1;
    end else if (r && sz > 0) begin
      m_data[k] = (k == 0) ? mq0.pop_front() : mq1.pop_front();
      m_hit[k] = 1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    tests_run++; if (ready_a !== 1'b1) begin failures++; $display("[TB] FAIL reset_loadReady got %0b want 1", ready_a); end
    tests_run++; if (data_a !== '0) begin failures++; $display("[TB] FAIL reset_inData got %0d want 0", data_a); end
    tests_run++; if ({hit_a, sealed_a, ovf_a} !== 3'b000) begin failures++; $display("[TB] FAIL reset_flags got %b want 000", {hit_a, sealed_a, ovf_a}); end
    tests_run++; if (size_a !== 2'd0) begin failures++; $display("[TB] FAIL reset_inSize got %0d want 0", size_a); end
    do_reset();
  endtask

  task automatic test_load_seal();
    drive(0, 1, 12'd88, 0, 0);
    tests_run++; if (size_a !== 2'd1) begin failures++; $display("[TB] FAIL load1_inSize got %0d want 1", size_a); end
    drive(0, 1, 12'd44, 0, 0);
    tests_run++; if (size_a !== 2'd2) begin failures++; $display("[TB] FAIL load2_inSize got %0d want 2", size_a); end
    tests_run++; if (ready_a !== 1'b0) begin failures++; $display("[TB] FAIL full_loadReady got %0b want 0", ready_a); end
    drive(0, 0, '0, 1, 0);
    tests_run++; if (sealed_a !== 1'b1) begin failures++; $display("[TB] FAIL seal_sealed got %0b want 1", sealed_a); end
  endtask

  task automatic test_drain();
    tests_run++; if (size_a !== 2'd2) begin failures++; $display("[TB] FAIL drain_size0 got %0d want 2", size_a); end
    drive(0, 0, '0, 0, 1);
    tests_run++; if ({hit_a, data_a} !== {1'b1, 12'd88}) begin failures++; $display("[TB] FAIL pop1 got hit=%0b data=%0d want hit=1 data=88", hit_a, data_a); end
    tests_run++; if (size_a !== 2'd1) begin failures++; $display("[TB] FAIL drain_size1 got %0d want 1", size_a); end
    idle();
    tests_run++; if (hit_a !== 1'b0) begin failures++; $display("[TB] FAIL hit_pulse got %0b want 0", hit_a); end
    drive(0, 0, '0, 0, 1);
    tests_run++; if ({hit_a, data_a} !== {1'b1, 12'd44}) begin failures++; $display("[TB] FAIL pop2 got hit=%0b data=%0d want hit=1 data=44", hit_a, data_a); end
    tests_run++; if (size_a !== 2'd0) begin failures++; $display("[TB] FAIL drain_size2 got %0d want 0", size_a); end
    drive(0, 0, '0, 0, 1);
    tests_run++; if ({hit_a, data_a, size_a} !== {1'b0, 12'd44, 2'd0}) begin failures++; $display("[TB] FAIL miss got hit=%0b data=%0d size=%0d want hit=0 data=44 size=0", hit_a, data_a, size_a); end
  endtask

  task automatic test_overflow();
    drive(1, 0, '0, 0, 0);
    tests_run++; if ({sealed_a, ovf_a, size_a} !== {1'b0, 1'b0, 2'd0}) begin failures++; $display("[TB] FAIL clear_state got sealed=%0b ovf=%0b size=%0d want 0 0 0", sealed_a, ovf_a, size_a); end
    drive(0, 1, 12'd88, 0, 0);
    drive(0, 1, 12'd44, 0, 1);
    tests_run++; if (hit_a !== 1'b0) begin failures++; $display("[TB] FAIL load_state_inReq got hit=%0b want 0", hit_a); end
    drive(0, 1, 12'd7, 0, 0);
    tests_run++; if ({ovf_a, size_a} !== {1'b1, 2'd2}) begin failures++; $display("[TB] FAIL overflow got ovf=%0b size=%0d want ovf=1 size=2", ovf_a, size_a); end
    drive(0, 0, '0, 1, 0);
    drive(0, 0, '0, 0, 1);
    tests_run++; if (data_a !== 12'd88) begin failures++; $display("[TB] FAIL ovf_pop1 got %0d want 88", data_a); end
    drive(0, 1, 12'd9, 0, 1);
    tests_run++; if ({data_a, size_a} !== {12'd44, 2'd0}) begin failures++; $display("[TB] FAIL ovf_pop2 got data=%0d size=%0d want 44 0", data_a, size_a); end
    drive(0, 1, 12'd9, 0, 1);
    tests_run++; if ({hit_a, ovf_a, ready_a} !== 3'b010) begin failures++; $display("[TB] FAIL run_load_ignored got hit/ovf/ready=%b want 010", {hit_a, ovf_a, ready_a}); end
  endtask

  task automatic test_wrap();
    drive(1, 0, '0, 0, 0);
    drive(0, 1, 12'd1, 0, 0);
    drive(0, 1, 12'd2, 1, 0);
    drive(0, 0, '0, 0, 1);
    tests_run++; if ({hit_b, data_b} !== {1'b1, 12'd1}) begin failures++; $display("[TB] FAIL wrap_run1 got hit=%0b data=%0d want 1 1", hit_b, data_b); end
    drive(1, 0, '0, 0, 0);
    drive(0, 1, 12'd5, 0, 0);
    drive(0, 1, 12'd6, 0, 0);
    drive(0, 1, 12'd7, 0, 0);
    tests_run++; if ({size_b, ready_b} !== {2'd3, 1'b0}) begin failures++; $display("[TB] FAIL wrap_full got size=%0d ready=%0b want 3 0", size_b, ready_b); end
    drive(0, 0, '0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, '0, 0, 1);
      tests_run++; if ({hit_b, data_b, size_b} !== {1'b1, W'(5 + i), 2'(2 - i)}) begin failures++; $display("[TB] FAIL wrap_pop%0d got hit=%0b data=%0d size=%0d want 1 %0d %0d", i, hit_b, data_b, size_b, 5 + i, 2 - i); end
    end
    drive(0, 0, '0, 0, 1);
    tests_run++; if ({hit_b, data_b} !== {1'b0, 12'd7}) begin failures++; $display("[TB] FAIL wrap_miss got hit=%0b data=%0d want 0 7", hit_b, data_b); end
  endtask

  task automatic test_clear_priority();
    drive(1, 0, '0, 0, 0);
    drive(0, 1, 12'd30, 1, 0);
    drive(1, 1, 12'd31, 1, 1);
    tests_run++; if ({hit_a, sealed_a, ovf_a, size_a, ready_a} !== {3'b000, 2'd0, 1'b1}) begin failures++; $display("[TB] FAIL clear_wins got hit/sealed/ovf=%b size=%0d ready=%0b want 000 0 1", {hit_a, sealed_a, ovf_a}, size_a, ready_a); end
  endtask

  task automatic test_reset_mid_drain();
    drive(0, 1, 12'd10, 0, 0);
    drive(0, 1, 12'd20, 1, 0);
    drive(0, 0, '0, 0, 1);
    tests_run++; if ({hit_a, data_a} !== {1'b1, 12'd10}) begin failures++; $display("[TB] FAIL pre_reset_pop got hit=%0b data=%0d want 1 10", hit_a, data_a); end
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++; if ({hit_a, sealed_a, ovf_a, size_a, data_a} !== {3'b000, 2'd0, 12'd0}) begin failures++; $display("[TB] FAIL async_reset got hit/sealed/ovf=%b size=%0d data=%0d want 000 0 0", {hit_a, sealed_a, ovf_a}, size_a, data_a); end
    @(negedge clock);
    rst_n = 1'b1;
    in_req = 0;
    @(posedge clock);
    #1;
    tests_run++; if ({hit_a, sealed_a, size_a, ready_a} !== {2'b00, 2'd0, 1'b1}) begin failures++; $display("[TB] FAIL after_reset got hit/sealed=%b size=%0d ready=%0b want 00 0 1", {hit_a, sealed_a}, size_a, ready_a); end
  endtask

  task automatic test_random();
    bit c, lv, s, r;
    logic [W-1:0] d;
    bit e_ready, a_ready, a_hit, a_sealed, a_ovf;
    logic [W-1:0] a_data;
    logic [1:0] a_size;
    int sz, depth;
    do_reset();
    model_reset();
    for (int n = 0; n < 300; n++) begin
      c  = ($urandom_range(0, 29) == 0);
      lv = $urandom_range(0, 1);
      s  = ($urandom_range(0, 7) == 0);
      r  = $urandom_range(0, 1);
      d  = W'($urandom);
      drive(c, lv, d, s, r);
      model_step(0, 2, c, lv, d, s, r);
      model_step(1, 3, c, lv, d, s, r);
      for (int k = 0; k < 2; k++) begin
        depth    = k + 2;
        sz       = (k == 0) ? mq0.size() : mq1.size();
        e_ready  = !m_sealed[k] && (sz < depth);
        a_ready  = k ? ready_b  : ready_a;
        a_hit    = k ? hit_b    : hit_a;
        a_sealed = k ? sealed_b : sealed_a;
        a_ovf    = k ? ovf_b    : ovf_a;
        a_data   = k ? data_b   : data_a;
        a_size   = k ? size_b   : size_a;
        tests_run++; if (a_hit !== m_hit[k]) begin failures++; $display("[TB] FAIL rnd%0d_inHit cycle %0d got %0b want %0b", k, n, a_hit, m_hit[k]); end
        tests_run++; if (a_data !== m_data[k]) begin failures++; $display("[TB] FAIL rnd%0d_inData cycle %0d got %0d want %0d", k, n, a_data, m_data[k]); end
        tests_run++; if (a_size !== 2'(sz)) begin failures++; $display("[TB] FAIL rnd%0d_inSize cycle %0d got %0d want %0d", k, n, a_size, sz); end
        tests_run++; if (a_ready !== e_ready) begin failures++; $display("[TB] FAIL rnd%0d_loadReady cycle %0d got %0b want %0b", k, n, a_ready, e_ready); end
        tests_run++; if (a_sealed !== m_sealed[k]) begin failures++; $display("[TB] FAIL rnd%0d_sealed cycle %0d got %0b want %0b", k, n, a_sealed, m_sealed[k]); end
        tests_run++; if (a_ovf !== m_ovf[k]) begin failures++; $display("[TB] FAIL rnd%0d_overflow cycle %0d got %0b want %0b", k, n, a_ovf, m_ovf[k]); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; clear = 0; load_valid = 0; load_data = '0; seal = 0; in_req = 0;
    #3;
    test_reset();
    test_load_seal();
    test_drain();
    test_overflow();
    test_wrap();
    test_clear_priority();
    test_reset_mid_drain();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
